// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared types for the fetch/data RAM arbiter: word type, FSM states,
// access kind and the request latched at grant.
package pipeline_mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, IACC, DACC, HALTED} arb_state_t;

  typedef enum logic {INSTR, DATA} arb_kind_t;

  typedef struct packed {
    arb_kind_t kind;
    logic      wen;
    word_t     addr;
    word_t     store;
  } arb_req_t;

endpackage

// File: rtl/pipeline_mem_arbiter_if.sv
// Bus bundle between the pipeline, the arbiter and the single-ported RAM.
// The arbiter sits on the slave modport; the pipeline/RAM side uses master.
interface pipeline_mem_arbiter_if;
  import pipeline_mem_arbiter_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t iload;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dhit;
  word_t dload;
  logic  flush;
  logic  halt;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ramready;
  logic  halted;
  logic  err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, flush, halt, ramload, ramready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, halted, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, flush, halt, ramload, ramready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, halted, err
  );

endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Data wins by default; a data-grant streak limit keeps fetch moving.
module pipeline_mem_arbiter
  import pipeline_mem_arbiter_pkg::*;
#(
  parameter int MAX_DSTREAK = 2,
  parameter int TIMEOUT     = 255
) (
  input logic                    CLK,
  input logic                    RST,
  pipeline_mem_arbiter_if.slave  bus
);

  localparam int DSW = $clog2(MAX_DSTREAK + 1);
  localparam logic [DSW-1:0] DS_MAX = DSW'(MAX_DSTREAK);
  localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_t     state_q, state_d;
  arb_req_t       req_q, req_d;
  logic [DSW-1:0] dstreak_q, dstreak_d;
  logic           cancel_q, cancel_d;
  logic [7:0]     tmo_q, tmo_d;
  logic           err_q, err_d;

  logic busy, tmo_hit, strobe, hit_ok;

  assign busy    = (state_q == IACC) || (state_q == DACC);
  assign tmo_hit = busy && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    dstreak_d = dstreak_q;
    cancel_d  = cancel_q;
    tmo_d     = tmo_q;
    err_d     = err_q;

    if (!bus.iREN) dstreak_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.halt && !bus.dREN && !bus.dWEN) begin
          state_d = HALTED;
        end else if (bus.iREN && !bus.halt && dstreak_q == DS_MAX) begin
          state_d   = IACC;
          req_d     = '{kind: INSTR, wen: 1'b0, addr: bus.iaddr, store: '0};
          dstreak_d = '0;
          tmo_d     = '0;
        end else if (bus.dREN || bus.dWEN) begin
          // A simultaneous read+write request is resolved as a write and flagged.
          state_d = DACC;
          req_d   = '{kind: DATA, wen: bus.dWEN, addr: bus.daddr, store: bus.dstore};
          tmo_d   = '0;
          if (bus.dREN && bus.dWEN) err_d = 1'b1;
          if (bus.iREN && dstreak_q != DS_MAX) dstreak_d = dstreak_q + 1'b1;
        end else if (bus.iREN && !bus.halt && !bus.flush) begin
          state_d   = IACC;
          req_d     = '{kind: INSTR, wen: 1'b0, addr: bus.iaddr, store: '0};
          dstreak_d = '0;
          tmo_d     = '0;
        end
      end
      IACC, DACC: begin
        tmo_d = tmo_q + 8'd1;
        if (state_q == IACC && bus.flush) cancel_d = 1'b1;
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (bus.ramready) begin
          state_d = IDLE;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase

    // A cancelled fetch is forgotten as soon as the access retires.
    if (state_d != IACC) cancel_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      req_q     <= '0;
      dstreak_q <= '0;
      cancel_q  <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      dstreak_q <= dstreak_d;
      cancel_q  <= cancel_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  // Strobes and hits are gated by RST so a reset mid-access releases the RAM at once.
  assign strobe = busy && !RST;
  assign hit_ok = strobe && bus.ramready && !tmo_hit;

  assign bus.ramREN   = strobe && !req_q.wen;
  assign bus.ramWEN   = strobe && req_q.wen;
  assign bus.ramaddr  = strobe ? req_q.addr : '0;
  assign bus.ramstore = (strobe && req_q.wen) ? req_q.store : '0;

  assign bus.ihit  = hit_ok && (state_q == IACC) && !cancel_q && !bus.flush;
  assign bus.dhit  = hit_ok && (state_q == DACC);
  assign bus.iload = bus.ihit ? bus.ramload : '0;
  assign bus.dload = (bus.dhit && !req_q.wen) ? bus.ramload : '0;

  assign bus.halted = (state_q == HALTED);
  assign bus.err    = err_q;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Scoreboard bench for pipeline_mem_arbiter: a behavioural RAM with programmable
// latency answers strobes; expected hits are queued at issue and checked on hit.
module tb_pipeline_mem_arbiter;
  import pipeline_mem_arbiter_pkg::*;

  logic CLK, RST;
  pipeline_mem_arbiter_if bus();

  pipeline_mem_arbiter #(.MAX_DSTREAK(2), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // RAM model: ramready pulses in the ram_lat-th consecutive strobe cycle.
  int          ram_lat = 1;
  bit          ram_en = 1'b1;
  int          ram_cnt;
  logic [31:0] mem [0:255];
  logic [255:0] written;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC0DE_0000 + {22'h0, a[9:0]} * 32'd3;
  endfunction

  assign bus.ramready = ram_en && (bus.ramREN || bus.ramWEN) && (ram_cnt == ram_lat - 1);
  assign bus.ramload  = written[bus.ramaddr[9:2]] ? mem[bus.ramaddr[9:2]] : pat(bus.ramaddr);

  always @(posedge CLK) begin
    if (RST || !(bus.ramREN || bus.ramWEN) || bus.ramready) ram_cnt <= 0;
    else ram_cnt <= ram_cnt + 1;
    if (RST) written <= '0;
    else if (bus.ramWEN && bus.ramready) begin
      mem[bus.ramaddr[9:2]]     <= bus.ramstore;
      written[bus.ramaddr[9:2]] <= 1'b1;
    end
  end

  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic idle_inputs;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.flush = 0; bus.halt = 0;
  endtask

  // Leaves the caller at a negedge with RST just released and the DUT in IDLE.
  task automatic apply_reset;
    @(negedge CLK);
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    @(negedge CLK);
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    n_chk++;
    if ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN});
    end
    RST = 1'b0;
    n_chk++;
    if (dut.state_q !== IDLE || bus.halted !== 1'b0 || bus.err !== 1'b0 || dut.dstreak_q !== 0) begin
      n_fail++; $display("FAIL reset_state: got state=%0d halted=%b err=%b dstreak=%0d expected IDLE/0/0/0",
                         dut.state_q, bus.halted, bus.err, dut.dstreak_q);
    end
  endtask

  task automatic test_fetch;
    int first_s = -1, n_s = 0, hit_c = -1;
    exp_t e;
    apply_reset();
    ram_en = 1; ram_lat = 2;
    exp_q.push_back('{is_d: 0, chk_data: 1, data: pat(32'h40)});
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge CLK);
      if (c == 0) begin bus.iREN = 1; bus.iaddr = 32'h40; end
      if (hit_c >= 0) bus.iREN = 0;
      #1;
      if (bus.ramREN) begin if (first_s < 0) first_s = c; n_s++; end
      if (c == 1) begin
        n_chk++;
        if (bus.ramaddr !== 32'h40) begin n_fail++; $display("FAIL fetch_addr: got %h expected 00000040", bus.ramaddr); end
      end
      if (bus.ihit || bus.dhit) begin
        hit_c = c;
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL fetch_hit: got unexpected hit expected none"); end
        else begin
          e = exp_q.pop_front();
          if (bus.dhit !== e.is_d || bus.iload !== e.data) begin
            n_fail++; $display("FAIL fetch_hit: got dhit=%b iload=%h expected dhit=%b iload=%h", bus.dhit, bus.iload, e.is_d, e.data);
          end
        end
      end
    end
    n_chk++;
    if (first_s !== 1 || n_s !== 2 || hit_c !== 2) begin
      n_fail++; $display("FAIL fetch_timing: got strobe@%0d x%0d hit@%0d expected strobe@1 x2 hit@2", first_s, n_s, hit_c);
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL fetch_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_streak;
    bit got_i = 0;
    exp_t e;
    apply_reset();
    ram_en = 1; ram_lat = 1;
    exp_q.push_back('{is_d: 1, chk_data: 1, data: pat(32'h200)});
    exp_q.push_back('{is_d: 1, chk_data: 1, data: pat(32'h200)});
    exp_q.push_back('{is_d: 0, chk_data: 1, data: pat(32'h20)});
    for (int c = 0; c < 30 && !got_i; c++) begin
      if (c > 0) @(negedge CLK);
      if (c == 0) begin bus.iREN = 1; bus.iaddr = 32'h20; bus.dREN = 1; bus.daddr = 32'h200; end
      #1;
      if (c == 4) begin
        n_chk++;
        if (dut.dstreak_q !== 2) begin n_fail++; $display("FAIL streak_sat: got %0d expected 2", dut.dstreak_q); end
      end
      if (bus.ihit || bus.dhit) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL streak_hit: got unexpected hit expected none"); end
        else begin
          e = exp_q.pop_front();
          if (bus.dhit !== e.is_d || (e.is_d ? bus.dload : bus.iload) !== e.data) begin
            n_fail++; $display("FAIL streak_hit: got dhit=%b data=%h expected dhit=%b data=%h",
                               bus.dhit, e.is_d ? bus.dload : bus.iload, e.is_d, e.data);
          end
        end
        if (bus.ihit) begin
          got_i = 1;
          n_chk++;
          if (dut.dstreak_q !== 0) begin n_fail++; $display("FAIL streak_clear: got %0d expected 0", dut.dstreak_q); end
        end
      end
    end
    @(negedge CLK);
    idle_inputs();
    n_chk++;
    if (!got_i || exp_q.size() != 0) begin n_fail++; $display("FAIL streak_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_flush;
    int new_s = -1, hit_c = -1;
    bit old_done = 0;
    exp_t e;
    apply_reset();
    ram_en = 1; ram_lat = 3;
    exp_q.push_back('{is_d: 0, chk_data: 1, data: pat(32'hC0)});
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge CLK);
      if (c == 0) begin bus.iREN = 1; bus.iaddr = 32'h80; end
      if (c == 2) begin bus.flush = 1; bus.iaddr = 32'hC0; end
      if (c == 3) bus.flush = 0;
      if (hit_c >= 0) bus.iREN = 0;
      #1;
      if (c == 3) begin
        n_chk++;
        if (bus.ramaddr !== 32'h80 || bus.ramready !== 1'b1 || bus.ihit !== 1'b0) begin
          n_fail++; $display("FAIL flush_cancel: got addr=%h ready=%b ihit=%b expected 00000080/1/0", bus.ramaddr, bus.ramready, bus.ihit);
        end
        old_done = 1;
      end
      if (bus.ramREN && bus.ramaddr == 32'hC0 && new_s < 0) new_s = c;
      if (bus.ihit || bus.dhit) begin
        hit_c = c;
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL flush_hit: got unexpected hit at %0d expected none", c); end
        else begin
          e = exp_q.pop_front();
          if (bus.dhit !== e.is_d || bus.iload !== e.data) begin
            n_fail++; $display("FAIL flush_hit: got iload=%h expected %h", bus.iload, e.data);
          end
        end
      end
    end
    n_chk++;
    if (!old_done || new_s !== 5 || hit_c !== 7) begin
      n_fail++; $display("FAIL flush_refetch: got strobe@%0d hit@%0d expected strobe@5 hit@7", new_s, hit_c);
    end
  endtask

  task automatic test_halt;
    int n_s = 0, last_s = -1, hit_c = -1;
    exp_t e;
    apply_reset();
    ram_en = 1; ram_lat = 2;
    exp_q.push_back('{is_d: 1, chk_data: 0, data: 32'h0});
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge CLK);
      if (c == 0) begin
        bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        bus.halt = 1; bus.iREN = 1; bus.iaddr = 32'h44;
      end
      if (hit_c >= 0) bus.dWEN = 0;
      #1;
      if (bus.ramREN || bus.ramWEN) begin n_s++; last_s = c; end
      if (bus.ihit || bus.dhit) begin
        hit_c = c;
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL halt_hit: got unexpected hit at %0d expected none", c); end
        else begin
          e = exp_q.pop_front();
          if (bus.dhit !== e.is_d) begin n_fail++; $display("FAIL halt_hit: got dhit=%b expected %b", bus.dhit, e.is_d); end
        end
      end
    end
    n_chk++;
    if (n_s !== 2 || last_s !== 2 || hit_c !== 2) begin
      n_fail++; $display("FAIL halt_strobes: got %0d strobes last@%0d hit@%0d expected 2 last@2 hit@2", n_s, last_s, hit_c);
    end
    n_chk++;
    if (bus.halted !== 1'b1 || dut.state_q !== HALTED) begin
      n_fail++; $display("FAIL halt_state: got halted=%b state=%0d expected 1/HALTED", bus.halted, dut.state_q);
    end
    n_chk++;
    if (written[8'h40] !== 1'b1 || mem[8'h40] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL halt_write: got %h expected deadbeef", mem[8'h40]);
    end
  endtask

  task automatic test_timeout;
    int n_s = 0, err_c = -1, n_hit = 0;
    apply_reset();
    ram_en = 0;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge CLK);
      if (c == 0) begin bus.dREN = 1; bus.daddr = 32'h10; end
      else bus.dREN = 0;
      #1;
      if (bus.ramREN || bus.ramWEN) n_s++;
      if (bus.ihit || bus.dhit) n_hit++;
      if (bus.err && err_c < 0) begin
        err_c = c;
        n_chk++;
        if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL timeout_state: got %0d expected IDLE", dut.state_q); end
      end
    end
    n_chk++;
    if (n_s !== 8 || err_c !== 9 || n_hit !== 0) begin
      n_fail++; $display("FAIL timeout: got strobes=%0d err@%0d hits=%0d expected 8 err@9 hits=0", n_s, err_c, n_hit);
    end
    ram_en = 1;
  endtask

  task automatic test_rst_mid;
    apply_reset();
    ram_en = 1; ram_lat = 5;
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h30; bus.dstore = 32'h1234;
    @(negedge CLK);
    bus.dREN = 0; bus.dWEN = 0;
    #1;
    n_chk++;
    if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.err !== 1'b1 || bus.ramstore !== 32'h1234) begin
      n_fail++; $display("FAIL rw_conflict: got wen=%b ren=%b err=%b store=%h expected 1/0/1/00001234",
                         bus.ramWEN, bus.ramREN, bus.err, bus.ramstore);
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_chk++;
    if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0) begin
      n_fail++; $display("FAIL rst_strobe_drop: got wen=%b ren=%b expected 0/0", bus.ramWEN, bus.ramREN);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_chk++;
    if (dut.state_q !== IDLE || {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.halted, bus.err} !== 6'b0 || bus.ramaddr !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid: got state=%0d outs=%b addr=%h expected IDLE/000000/0", dut.state_q,
                         {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.halted, bus.err}, bus.ramaddr);
    end
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_streak();
    test_flush();
    test_halt();
    test_timeout();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
